// File: rtl/stage5_quote_encoder.sv
// rtl/stage5_quote_encoder.sv - serialises one 'q' quote record into a framed byte stream with XOR checksum
module stage5_quote_encoder #(
  parameter int         FIELD_BYTES = 4,
  parameter logic [7:0] MSG_TYPE    = 8'h71,
  parameter int         CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enc_en,
  input  logic                     fld_valid,
  output logic                     fld_ready,
  input  logic [31:0]              fld_symbol,
  input  logic [8*FIELD_BYTES-1:0] fld_bp1,
  input  logic [8*FIELD_BYTES-1:0] fld_bp2,
  input  logic [8*FIELD_BYTES-1:0] fld_bp3,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     busy,
  output logic [CNT_W-1:0]         msg_cnt
);

  localparam int FW       = 8 * FIELD_BYTES;
  localparam int MSG_LEN  = 6 + 3 * FIELD_BYTES;
  localparam int BODY_LEN = MSG_LEN - 1;
  localparam int IDX_W    = $clog2(MSG_LEN);

  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;

  state_t             state, state_nxt;
  logic [31:0]        sym_q;
  logic [FW-1:0]      bp1_q, bp2_q, bp3_q;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         acc;
  logic [7:0]         cur_byte;
  logic [BODY_LEN*8-1:0] body;
  logic               load;

  assign body = {MSG_TYPE, sym_q, bp1_q, bp2_q, bp3_q};
  assign load = fld_valid && fld_ready;

  // Body byte mux driven only by registered state, so out_ready never reaches out_data.
  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < BODY_LEN; i++) begin
      if (idx == IDX_W'(i)) cur_byte = body[(BODY_LEN-1-i)*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = SEND;
      SEND: if (out_ready && idx == IDX_W'(BODY_LEN-1)) state_nxt = CSUM;
      CSUM: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fld_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: fld_ready = enc_en && rst_n;
      SEND: begin
        out_valid = 1'b1;
        out_data  = cur_byte;
        out_sop   = (idx == '0);
        busy      = 1'b1;
      end
      CSUM: begin
        out_valid = 1'b1;
        out_data  = acc;
        out_eop   = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q   <= '0;
      bp1_q   <= '0;
      bp2_q   <= '0;
      bp3_q   <= '0;
      idx     <= '0;
      acc     <= '0;
      msg_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          sym_q <= fld_symbol;
          bp1_q <= fld_bp1;
          bp2_q <= fld_bp2;
          bp3_q <= fld_bp3;
          idx   <= '0;
          acc   <= '0;
        end
        SEND: if (out_ready) begin
          acc <= acc ^ cur_byte;
          idx <= idx + IDX_W'(1);
        end
        CSUM: if (out_ready) msg_cnt <= msg_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage5_quote_encoder.sv
// tb/tb_stage5_quote_encoder.sv - scoreboard bench for stage5_quote_encoder (CNT_W=2 to exercise wrap)
module tb_stage5_quote_encoder;

  logic        clk = 1'b0;
  logic        rst_n, enc_en, fld_valid, fld_ready;
  logic [31:0] fld_symbol, fld_bp1, fld_bp2, fld_bp3;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_sop, out_eop, busy;
  logic [1:0]  msg_cnt;

  always #5 clk = ~clk;

  stage5_quote_encoder #(.FIELD_BYTES(4), .MSG_TYPE(8'h71), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .enc_en(enc_en),
    .fld_valid(fld_valid), .fld_ready(fld_ready),
    .fld_symbol(fld_symbol), .fld_bp1(fld_bp1), .fld_bp2(fld_bp2), .fld_bp3(fld_bp3),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .msg_cnt(msg_cnt)
  );

  typedef struct packed {logic [7:0] d; logic sop; logic eop;} exp_t;
  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         acc_cnt = 0;
  bit         bp_mode = 1'b0;
  bit         stalled = 1'b0;
  logic [7:0] hold_d;
  logic       hold_sop, hold_eop;
  logic [7:0] last_eop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_msg(input logic [31:0] s, b1, b2, b3);
    logic [7:0] bytes [17];
    logic [7:0] x;
    bytes[0] = 8'h71;
    for (int i = 0; i < 4; i++) begin
      bytes[1+i]  = s[31-8*i -: 8];
      bytes[5+i]  = b1[31-8*i -: 8];
      bytes[9+i]  = b2[31-8*i -: 8];
      bytes[13+i] = b3[31-8*i -: 8];
    end
    x = 8'h00;
    for (int i = 0; i < 17; i++) begin
      x = x ^ bytes[i];
      exp_q.push_back('{d: bytes[i], sop: (i == 0), eop: 1'b0});
    end
    exp_q.push_back('{d: x, sop: 1'b0, eop: 1'b1});
  endfunction

  always @(negedge clk) begin
    if (bp_mode) out_ready = ~out_ready;
  end

  // Monitor: samples after the stimulus edge settles, pops one entry per accepted byte.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) begin
        check("stall_data", out_data, hold_d);
        check("stall_sop", out_sop, hold_sop);
        check("stall_eop", out_eop, hold_eop);
      end
      stalled  = out_valid && !out_ready;
      hold_d   = out_data;
      hold_sop = out_sop;
      hold_eop = out_eop;
      if (out_valid && out_ready) begin
        check("queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("byte_data", out_data, e.d);
          check("byte_sop", out_sop, e.sop);
          check("byte_eop", out_eop, e.eop);
        end
        acc_cnt++;
        if (out_eop) last_eop = out_data;
      end
    end
  end

  task automatic load(input logic [31:0] s, b1, b2, b3);
    @(negedge clk);
    fld_symbol = s; fld_bp1 = b1; fld_bp2 = b2; fld_bp3 = b3;
    fld_valid = 1'b1;
    #1;
    check("load_ready", fld_ready, 1);
    push_msg(s, b1, b2, b3);
    @(negedge clk);
    fld_valid = 1'b0;
    #1;
    check("busy_after_load", busy, 1);
    check("first_byte_sop", out_sop, 1);
    check("first_byte_type", out_data, 8'h71);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((busy || exp_q.size() != 0) && n < 300);
    check("idle_busy", busy, 0);
    check("idle_queue", exp_q.size(), 0);
    check("ready_after_eop", fld_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; enc_en = 1'b1; fld_valid = 1'b0; out_ready = 1'b1;
    fld_symbol = '0; fld_bp1 = '0; fld_bp2 = '0; fld_bp3 = '0;
    #12;
    check("rst_fld_ready", fld_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sop", out_sop, 0);
    check("rst_eop", out_eop, 0);
    check("rst_busy", busy, 0);
    check("rst_msg_cnt", msg_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", fld_ready, 1);

    // Single record, no backpressure
    base = acc_cnt;
    load(32'h41424344, 32'h64, 32'h63, 32'h62);
    wait_idle();
    check("single_bytes", acc_cnt - base, 18);
    check("single_csum", last_eop, 8'h10);
    check("single_cnt", msg_cnt, 1);

    // Backpressure toggling every cycle
    base = acc_cnt;
    bp_mode = 1'b1;
    load(32'h41424344, 32'h64, 32'h63, 32'h62);
    wait_idle();
    bp_mode = 1'b0;
    out_ready = 1'b1;
    check("bp_bytes", acc_cnt - base, 18);
    check("bp_csum", last_eop, 8'h10);
    check("bp_cnt", msg_cnt, 2);

    // enc_en low holds off acceptance
    @(negedge clk);
    enc_en = 1'b0;
    fld_symbol = 32'h5a5a0001; fld_bp1 = 32'h01020304; fld_bp2 = 32'h0; fld_bp3 = 32'hffffffff;
    fld_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("en_off_ready", fld_ready, 0);
      check("en_off_valid", out_valid, 0);
    end
    check("en_off_cnt", msg_cnt, 2);
    @(negedge clk);
    enc_en = 1'b1;
    #1;
    check("en_on_ready", fld_ready, 1);
    push_msg(fld_symbol, fld_bp1, fld_bp2, fld_bp3);
    @(negedge clk);
    fld_valid = 1'b0;
    #1;
    check("en_on_busy", busy, 1);
    wait_idle();
    check("en_cnt", msg_cnt, 3);

    // Inputs change right after capture
    load(32'h41424344, 32'h64, 32'h63, 32'h62);
    fld_bp2 = 32'hffffffff;
    fld_symbol = 32'hdeadbeef;
    wait_idle();
    check("chg_csum", last_eop, 8'h10);
    check("chg_cnt_wrap", msg_cnt, 0);

    // Reset while byte 7 is on the bus
    load(32'h41424344, 32'h11223344, 32'h63, 32'h62);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_eop", out_eop, 0);
    check("midrst_cnt", msg_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load(32'h00000000, 32'h0, 32'h80000001, 32'h7f);
    wait_idle();
    check("postrst_cnt", msg_cnt, 1);

    // Counter wrap over five back-to-back messages from reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load($urandom, $urandom, $urandom, $urandom);
      wait_idle();
      check("wrap_cnt", msg_cnt, 32'((i + 1) % 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
